f1_light_seq: RTL and testbench

- Parametrised start-light sequencer for the F1 reaction-timer datapath; generalises the fixed 8-light shift-fill FSM.
- Fills WIDTH lights one per tick, holds all lit for a programmable delay, then extinguishes them all at once and pulses lights_out to start the downstream reaction timer.
- Adds trigger/abort control, a busy flag and a restart lockout. Sits between the tick clock divider and the LED/timer blocks.

---
 rtl/f1_light_seq.sv | 106 ++++++++++
 tb/tb_f1_light_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fills WIDTH lights one per tick, holds, then blanks and pulses lights_out.
// Optional F1_RAND_DELAY_EN: the hold length comes from a free-running Galois LFSR instead of delay.
module f1_light_seq #(
   parameter int unsigned   WIDTH = 8,
   parameter int unsigned   DW    = 7,
   parameter logic [DW-1:0] TAPS  = 7'h60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             trigger,
   input  logic             abort,
   input  logic [DW-1:0]    delay,
   output logic [WIDTH-1:0] data_out,
   output logic             lights_out,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StFill, StHold, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [DW-1:0]    cnt_q, cnt_d;
   logic             lights_q, lights_d;
   logic             busy_q, busy_d;
   logic [DW-1:0]    load_val;

`ifdef F1_RAND_DELAY_EN
   logic [DW-1:0] lfsr_q, lfsr_d;
   logic          unused_delay;

   // Free-running, not tick-gated and not reseeded by abort; a non-zero seed never reaches zero.
   always_comb lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= DW'(1);
      else     lfsr_q <= lfsr_d;
   end

   assign load_val     = lfsr_q;
   assign unused_delay = ^delay;
`else
   assign load_val = delay;
`endif

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      lights_d = 1'b0;
      unique case (state_q)
         StIdle: if (trigger) state_d = StFill;
         StFill: begin
            if (tick) begin
               data_d = {data_q[WIDTH-2:0], 1'b1};
               // This tick lights the last lamp: latch the hold length now.
               if (&data_q[WIDTH-2:0]) begin
                  cnt_d   = load_val;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (tick) begin
               if (cnt_q == '0) begin
                  data_d   = '0;
                  lights_d = 1'b1;
                  state_d  = StDone;
               end else begin
                  cnt_d = cnt_q - DW'(1);
               end
            end
         end
         StDone: if (!trigger) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort && (state_q != StIdle)) begin
         state_d  = StIdle;
         data_d   = '0;
         lights_d = 1'b0;
         cnt_d    = '0;
      end
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         data_q   <= '0;
         cnt_q    <= '0;
         lights_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         lights_q <= lights_d;
         busy_q   <= busy_d;
      end
   end

   assign data_out   = data_q;
   assign lights_out = lights_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_f1_light_seq.sv
// Scoreboard bench for f1_light_seq: stimulus pushes per-cycle expected outputs, a monitor pops and
// compares after every clock edge. Follows F1_RAND_DELAY_EN with a reference LFSR when defined.
module tb_f1_light_seq;

   logic       clk, rst, tick, trigger, abort;
   logic [6:0] delay;
   logic [7:0] data_out;
   logic       lights_out, busy;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       b;
      string      nm;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   hl;
   logic [6:0] lm;

   f1_light_seq #(.WIDTH(8), .DW(7), .TAPS(7'h60)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .trigger   (trigger),
      .abort     (abort),
      .delay     (delay),
      .data_out  (data_out),
      .lights_out(lights_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR, seeded to 1 on rst.
   always @(posedge clk) begin
      if (rst) lm <= 7'd1;
      else     lm <= lm[0] ? ((lm >> 1) ^ 7'h60) : (lm >> 1);
   end

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_cmp++;
         if ({data_out, lights_out, busy} !== {e.d, e.l, e.b}) begin
            n_bad++;
            $display("FAIL %s: got data=%h lights=%b busy=%b, want data=%h lights=%b busy=%b",
                     e.nm, data_out, lights_out, busy, e.d, e.l, e.b);
         end
      end
   end

   task automatic cyc(input logic r, input logic t, input logic tr, input logic ab,
                      input logic [6:0] dl, input logic [7:0] ed, input logic el,
                      input logic eb, input string nm);
      @(negedge clk);
      rst = r; tick = t; trigger = tr; abort = ab; delay = dl;
      q.push_back('{d: ed, l: el, b: eb, nm: nm});
      @(posedge clk);
   endtask

   // Trigger from IDLE, then fill all 8 lights with a tick every per cycles.
   task automatic seq_fill(input int per, input logic tr, input logic [6:0] d, input string nm,
                           output int hold_len);
      logic [7:0] pat;
      pat = 8'h00;
      cyc(1'b0, 1'b1, 1'b1, 1'b0, d, 8'h00, 1'b0, 1'b1, {nm, "_trig"});
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < per - 1; k++)
            cyc(1'b0, 1'b0, tr, 1'b0, d, pat, 1'b0, 1'b1, {nm, "_fill_wait"});
         pat = {pat[6:0], 1'b1};
         if (i == 7) begin
            #2;
`ifdef F1_RAND_DELAY_EN
            hold_len = int'(lm) + 1;
`else
            hold_len = int'(d) + 1;
`endif
         end
         cyc(1'b0, 1'b1, tr, 1'b0, d, pat, 1'b0, 1'b1, {nm, "_fill"});
      end
   endtask

   // Remaining hold ticks after the fill edge, ending on the blanking edge with lights_out.
   task automatic seq_hold(input int per, input logic tr, input int hold_len,
                           input logic [6:0] d, input string nm);
      for (int j = 1; j < hold_len; j++) begin
         for (int k = 0; k < per - 1; k++)
            cyc(1'b0, 1'b0, tr, 1'b0, d, 8'hff, 1'b0, 1'b1, {nm, "_hold_wait"});
         cyc(1'b0, 1'b1, tr, 1'b0, d, 8'hff, 1'b0, 1'b1, {nm, "_hold"});
      end
      for (int k = 0; k < per - 1; k++)
         cyc(1'b0, 1'b0, tr, 1'b0, d, 8'hff, 1'b0, 1'b1, {nm, "_hold_wait"});
      cyc(1'b0, 1'b1, tr, 1'b0, d, 8'h00, 1'b1, 1'b1, {nm, "_lights_out"});
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; trigger = 1'b0; abort = 1'b0; delay = 7'd0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, "reset");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, "idle_tick");

      // Basic run, tick every cycle, delay=3; delay changed after HOLD entry must not matter.
      seq_fill(1, 1'b0, 7'd3, "t1", hl);
      seq_hold(1, 1'b0, hl, 7'd0, "t1");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, "t1_done_exit");

      // Tick every 4th cycle, delay=0.
      seq_fill(4, 1'b0, 7'd0, "t2", hl);
      seq_hold(4, 1'b0, hl, 7'd0, "t2");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, "t2_done_exit");

      // Abort at 07, then restart from 01; abort in IDLE is harmless.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 7'd2, 8'h00, 1'b0, 1'b1, "t3_trig");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd2, 8'h01, 1'b0, 1'b1, "t3_fill1");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd2, 8'h03, 1'b0, 1'b1, "t3_fill2");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd2, 8'h07, 1'b0, 1'b1, "t3_fill3");
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 7'd2, 8'h00, 1'b0, 1'b0, "t3_abort");
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 7'd2, 8'h00, 1'b0, 1'b0, "t3_abort_idle");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 7'd2, 8'h00, 1'b0, 1'b1, "t3_retrig");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd2, 8'h01, 1'b0, 1'b1, "t3_refill");
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 7'd2, 8'h00, 1'b0, 1'b0, "t3_abort2");

      // Trigger held high through completion: lockout in DONE.
      seq_fill(1, 1'b1, 7'd0, "t4", hl);
      seq_hold(1, 1'b1, hl, 7'd0, "t4");
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1, "t4_lockout1");
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1, "t4_lockout2");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, "t4_release");

      // rst during HOLD.
      seq_fill(1, 1'b0, 7'd5, "t5", hl);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd5, 8'hff, 1'b0, 1'b1, "t5_hold");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 7'd5, 8'h00, 1'b0, 1'b0, "t5_rst");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd5, 8'h00, 1'b0, 1'b0, "t5_after_rst");

      // Abort coincident with the final HOLD tick.
      seq_fill(1, 1'b0, 7'd1, "t6", hl);
      for (int j = 1; j < hl; j++)
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 8'hff, 1'b0, 1'b1, "t6_hold");
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 7'd1, 8'h00, 1'b0, 1'b0, "t6_abort_final");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 8'h00, 1'b0, 1'b0, "t6_after");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 8'h00, 1'b0, 1'b0, "t6_idle");

      repeat (2) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
